// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the hazard unit: the hazard_optype encoding coming
// out of decode, the operand-forwarding select encoding driven into ID, the
// shadow-slot record {rd, optype, ls} and two small helpers used to look up
// a slot and pick a forwarding source.
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int HZ_REG_AW = 5;
  localparam int HZ_OPT_W  = 2;

  typedef enum logic [HZ_OPT_W-1:0] {
    OPT_NONE  = 2'b00,
    OPT_ALU   = 2'b01,
    OPT_LOAD  = 2'b10,
    OPT_STORE = 2'b11
  } optype_e;

  typedef enum logic [1:0] {
    FWD_RF      = 2'd0,
    FWD_EXE_ALU = 2'd1,
    FWD_MEM_ALU = 2'd2,
    FWD_MEM_LD  = 2'd3
  } fwd_sel_e;

  // ls marks a store whose data must be taken from the load data in WB once
  // that store reaches MEM.
  typedef struct packed {
    logic [HZ_REG_AW-1:0] rd;
    optype_e              optype;
    logic                 ls;
  } slot_t;

  // A slot supplies a source register only if it will really write it back.
  // Stores carry no destination, and x0 is never a dependency.
  function automatic logic slot_hit(slot_t s, logic [HZ_REG_AW-1:0] rs,
                                    logic rs_used);
    return rs_used && (rs != '0) && (s.rd == rs) &&
           ((s.optype == OPT_ALU) || (s.optype == OPT_LOAD));
  endfunction

  // EXE holds the youngest producer, so it shadows MEM. A load still in EXE
  // has no data yet, which leaves the select at the regfile; that case is
  // covered by the stall or by the store-data path instead.
  function automatic fwd_sel_e fwd_pick(logic exe_hit, optype_e exe_op,
                                        logic mem_hit, optype_e mem_op);
    if (exe_hit) begin
      return (exe_op == OPT_ALU) ? FWD_EXE_ALU : FWD_RF;
    end
    if (mem_hit) begin
      return (mem_op == OPT_ALU) ? FWD_MEM_ALU : FWD_MEM_LD;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_slot_reg.sv
// ---------------------------------------------------------------------------
// hazard_slot_reg
// One shadow pipeline slot {rd, optype, ls}.
//   i_clk     core clock
//   i_rst_n   synchronous active-low clear
//   i_bubble  load an empty entry instead of the incoming one
//   i_rd, i_optype, i_ls   incoming entry
//   o_rd, o_optype, o_ls   registered entry
// ---------------------------------------------------------------------------
module hazard_slot_reg
  import hazard_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_bubble,
  input  logic [HZ_REG_AW-1:0] i_rd,
  input  logic [HZ_OPT_W-1:0]  i_optype,
  input  logic                 i_ls,
  output logic [HZ_REG_AW-1:0] o_rd,
  output logic [HZ_OPT_W-1:0]  o_optype,
  output logic                 o_ls
);

  slot_t r_slot;

  // Writes to x0 are discarded by the core, so such an entry is stored as
  // non-writing to keep it from ever matching a source register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_bubble) begin
      r_slot <= '{rd: '0, optype: OPT_NONE, ls: 1'b0};
    end else begin
      r_slot.rd     <= i_rd;
      r_slot.optype <= (i_rd == '0) ? OPT_NONE : optype_e'(i_optype);
      r_slot.ls     <= i_ls;
    end
  end

  assign o_rd     = r_slot.rd;
  assign o_optype = r_slot.optype;
  assign o_ls     = r_slot.ls;

endmodule

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Stall, flush and operand-forwarding control for a 5-stage core whose
// branches resolve in ID. Tracks destination/optype of the instructions in
// EXE, MEM and WB in a private shadow pipeline.
//   i_clk, i_rst               clock, synchronous active-low reset
//   i_rs1_ID/i_rs2_ID/i_rd_ID  ID register addresses
//   i_rs1use_ID/i_rs2use_ID    ID instruction reads rs1/rs2
//   i_hazard_optype_ID         00 none, 01 ALU, 10 load, 11 store
//   i_Branch_ID                taken branch/jump decided in ID
//   o_forward_ctrl_A/B         ID operand select (0 RF, 1 EXE ALU,
//                              2 MEM ALU, 3 MEM load data)
//   o_forward_ctrl_ls          store in MEM takes WB load data
//   o_PC_EN_IF, o_reg_FD_EN    PC and IF/ID enables
//   o_reg_FD_flush             IF/ID flush (taken branch)
//   o_reg_DE_flush             ID/EXE bubble (load-use stall)
// ---------------------------------------------------------------------------
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = HZ_REG_AW,
  parameter int OPT_W  = HZ_OPT_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_rs1_ID,
  input  logic [REG_AW-1:0] i_rs2_ID,
  input  logic [REG_AW-1:0] i_rd_ID,
  input  logic              i_rs1use_ID,
  input  logic              i_rs2use_ID,
  input  logic [OPT_W-1:0]  i_hazard_optype_ID,
  input  logic              i_Branch_ID,
  output logic [1:0]        o_forward_ctrl_A,
  output logic [1:0]        o_forward_ctrl_B,
  output logic              o_forward_ctrl_ls,
  output logic              o_PC_EN_IF,
  output logic              o_reg_FD_EN,
  output logic              o_reg_FD_flush,
  output logic              o_reg_DE_flush
);

  logic [REG_AW-1:0] w_exe_rd, w_mem_rd, w_wb_rd;
  logic [OPT_W-1:0]  w_exe_op, w_mem_op, w_wb_op;
  logic              w_exe_ls, w_mem_ls, w_wb_ls;
  slot_t             w_exe, w_mem;
  optype_e           w_id_op;

  logic     w_a_exe_hit, w_a_mem_hit, w_b_exe_hit, w_b_mem_hit;
  logic     w_a_load_use, w_b_load_use, w_store_bypass, w_stall;
  fwd_sel_e w_fwd_a, w_fwd_b;

  // EXE is the only slot that can receive a bubble; MEM and WB always advance.
  hazard_slot_reg u_slot_exe (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst),
    .i_bubble (w_stall),
    .i_rd     (i_rd_ID),
    .i_optype (i_hazard_optype_ID),
    .i_ls     (w_store_bypass),
    .o_rd     (w_exe_rd),
    .o_optype (w_exe_op),
    .o_ls     (w_exe_ls)
  );

  hazard_slot_reg u_slot_mem (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst),
    .i_bubble (1'b0),
    .i_rd     (w_exe_rd),
    .i_optype (w_exe_op),
    .i_ls     (w_exe_ls),
    .o_rd     (w_mem_rd),
    .o_optype (w_mem_op),
    .o_ls     (w_mem_ls)
  );

  hazard_slot_reg u_slot_wb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst),
    .i_bubble (1'b0),
    .i_rd     (w_mem_rd),
    .i_optype (w_mem_op),
    .i_ls     (w_mem_ls),
    .o_rd     (w_wb_rd),
    .o_optype (w_wb_op),
    .o_ls     (w_wb_ls)
  );

  // WB is tracked to mirror the core's depth but never forwarded from: the
  // regfile writes in the first half-cycle, so ID already reads fresh data.
  logic w_wb_unused;
  assign w_wb_unused = ^{w_wb_rd, w_wb_op, w_wb_ls};

  assign w_exe   = '{rd: w_exe_rd, optype: optype_e'(w_exe_op), ls: w_exe_ls};
  assign w_mem   = '{rd: w_mem_rd, optype: optype_e'(w_mem_op), ls: w_mem_ls};
  assign w_id_op = optype_e'(i_hazard_optype_ID);

  assign w_a_exe_hit = slot_hit(w_exe, i_rs1_ID, i_rs1use_ID);
  assign w_a_mem_hit = slot_hit(w_mem, i_rs1_ID, i_rs1use_ID);
  assign w_b_exe_hit = slot_hit(w_exe, i_rs2_ID, i_rs2use_ID);
  assign w_b_mem_hit = slot_hit(w_mem, i_rs2_ID, i_rs2use_ID);

  assign w_fwd_a = fwd_pick(w_a_exe_hit, w_exe.optype, w_a_mem_hit, w_mem.optype);
  assign w_fwd_b = fwd_pick(w_b_exe_hit, w_exe.optype, w_b_mem_hit, w_mem.optype);

  assign w_a_load_use = w_a_exe_hit && (w_exe.optype == OPT_LOAD);
  assign w_b_load_use = w_b_exe_hit && (w_exe.optype == OPT_LOAD);

  // A store only needs the loaded value as write data, which is not used
  // until MEM. By then the load sits in WB, so the data is patched in there
  // rather than stalling. This only helps when rs1 (the address) is not
  // itself waiting on the load.
  assign w_store_bypass = (w_id_op == OPT_STORE) && w_b_load_use && !w_a_load_use;

  // Gating with reset makes a stall that was pending when reset arrived
  // vanish immediately instead of inserting a bubble.
  assign w_stall = i_rst && (w_a_load_use || (w_b_load_use && !w_store_bypass));

  // A stall holds the ID instruction, so a branch decision made from its
  // stale operands must not flush IF/ID; it is honoured on the retry.
  always_comb begin
    o_forward_ctrl_A  = FWD_RF;
    o_forward_ctrl_B  = FWD_RF;
    o_forward_ctrl_ls = 1'b0;
    o_PC_EN_IF        = 1'b1;
    o_reg_FD_EN       = 1'b1;
    o_reg_FD_flush    = 1'b0;
    o_reg_DE_flush    = 1'b0;
    if (i_rst) begin
      o_forward_ctrl_A  = w_fwd_a;
      o_forward_ctrl_B  = w_fwd_b;
      o_forward_ctrl_ls = w_mem.ls;
      if (w_stall) begin
        o_PC_EN_IF     = 1'b0;
        o_reg_FD_EN    = 1'b0;
        o_reg_DE_flush = 1'b1;
      end else begin
        o_reg_FD_flush = i_Branch_ID;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
// Self-checking bench for hazard_unit: directed instruction pairs with
// hand-computed expectations, then randomized instruction streams checked
// every cycle against an instruction-history model.
// ---------------------------------------------------------------------------
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       rs1use, rs2use;
  logic [1:0] optype;
  logic       branch;
  logic [1:0] fwdA, fwdB;
  logic       fwdLs, pcEn, fdEn, fdFlush, deFlush;

  int  nChecks;
  int  nFails;
  bit  checkOn;

  // Instruction history: index 0 is the instruction issued one cycle ago
  // (now in EXE), 1 two cycles ago (MEM), 2 three cycles ago (WB).
  int  histRd[3];
  int  histOp[3];
  bit  histLs[3];

  localparam int OP_NONE  = 0;
  localparam int OP_ALU   = 1;
  localparam int OP_LOAD  = 2;
  localparam int OP_STORE = 3;

  hazard_unit dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_rs1_ID           (rs1),
    .i_rs2_ID           (rs2),
    .i_rd_ID            (rd),
    .i_rs1use_ID        (rs1use),
    .i_rs2use_ID        (rs2use),
    .i_hazard_optype_ID (optype),
    .i_Branch_ID        (branch),
    .o_forward_ctrl_A   (fwdA),
    .o_forward_ctrl_B   (fwdB),
    .o_forward_ctrl_ls  (fwdLs),
    .o_PC_EN_IF         (pcEn),
    .o_reg_FD_EN        (fdEn),
    .o_reg_FD_flush     (fdFlush),
    .o_reg_DE_flush     (deFlush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int a1, input int a2, input int ad,
                               input int u1, input int u2, input int op, input int br);
    rs1    = 5'(a1);
    rs2    = 5'(a2);
    rd     = 5'(ad);
    rs1use = (u1 != 0);
    rs2use = (u2 != 0);
    optype = 2'(op);
    branch = (br != 0);
  endtask

  // Which older instruction supplies register rs:
  // 0 none, 1 ALU one back, 2 load one back, 3 ALU two back, 4 load two back.
  function automatic int producer(int rs, bit used);
    for (int age = 0; age < 2; age++) begin
      if (used && rs != 0 && histRd[age] == rs &&
          (histOp[age] == OP_ALU || histOp[age] == OP_LOAD)) begin
        return 2 * age + ((histOp[age] == OP_ALU) ? 1 : 2);
      end
    end
    return 0;
  endfunction

  function automatic int selectFor(int src);
    case (src)
      1:       return 1;
      3:       return 2;
      4:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic void modelEval(output int eA, output int eB, output int eLs,
                                    output int ePc, output int eFdEn,
                                    output int eFdFl, output int eDeFl,
                                    output bit stall, output bit bypass);
    int  srcA;
    int  srcB;
    bit  waitA;
    bit  waitB;
    srcA   = producer(int'(rs1), rs1use);
    srcB   = producer(int'(rs2), rs2use);
    waitA  = (srcA == 2);
    waitB  = (srcB == 2);
    bypass = (int'(optype) == OP_STORE) && waitB && !waitA;
    stall  = rst && (waitA || (waitB && !bypass));
    eA = 0; eB = 0; eLs = 0; ePc = 1; eFdEn = 1; eFdFl = 0; eDeFl = 0;
    if (rst) begin
      eA    = selectFor(srcA);
      eB    = selectFor(srcB);
      eLs   = histLs[1] ? 1 : 0;
      ePc   = stall ? 0 : 1;
      eFdEn = stall ? 0 : 1;
      eDeFl = stall ? 1 : 0;
      eFdFl = (!stall && branch) ? 1 : 0;
    end
  endfunction

  // Model advance at each rising edge, using the inputs present at the edge.
  initial begin
    int  eA, eB, eLs, ePc, eFdEn, eFdFl, eDeFl;
    bit  stall, bypass;
    forever begin
      @(posedge clk);
      modelEval(eA, eB, eLs, ePc, eFdEn, eFdFl, eDeFl, stall, bypass);
      if (!rst) begin
        for (int k = 0; k < 3; k++) begin
          histRd[k] = 0; histOp[k] = OP_NONE; histLs[k] = 1'b0;
        end
        checkOn = 1'b1;
      end else begin
        histRd[2] = histRd[1]; histOp[2] = histOp[1]; histLs[2] = histLs[1];
        histRd[1] = histRd[0]; histOp[1] = histOp[0]; histLs[1] = histLs[0];
        if (stall) begin
          histRd[0] = 0; histOp[0] = OP_NONE; histLs[0] = 1'b0;
        end else begin
          histRd[0] = int'(rd);
          histOp[0] = (rd == 5'd0) ? OP_NONE : int'(optype);
          histLs[0] = bypass;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    int  eA, eB, eLs, ePc, eFdEn, eFdFl, eDeFl;
    bit  stall, bypass;
    forever begin
      @(negedge clk);
      if (checkOn) begin
        modelEval(eA, eB, eLs, ePc, eFdEn, eFdFl, eDeFl, stall, bypass);
        checkOutput("fwdA",    int'(fwdA),    eA);
        checkOutput("fwdB",    int'(fwdB),    eB);
        checkOutput("fwdLs",   int'(fwdLs),   eLs);
        checkOutput("pcEn",    int'(pcEn),    ePc);
        checkOutput("fdEn",    int'(fdEn),    eFdEn);
        checkOutput("fdFlush", int'(fdFlush), eFdFl);
        checkOutput("deFlush", int'(deFlush), eDeFl);
      end
    end
  end

  // Issue one ID instruction just after an edge and settle before checking.
  task automatic issue(input int a1, input int a2, input int ad,
                       input int u1, input int u2, input int op, input int br);
    @(posedge clk);
    #1;
    applyStimulus(a1, a2, ad, u1, u2, op, br);
    #3;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) issue(0, 0, 0, 0, 0, OP_NONE, 0);
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    checkOn = 1'b0;
    rst     = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, OP_NONE, 0);
    #3;
    checkOutput("rstPcEn",    int'(pcEn),    1);
    checkOutput("rstFdEn",    int'(fdEn),    1);
    checkOutput("rstDeFlush", int'(deFlush), 0);
    idle(2);
    rst = 1'b1;
    idle(2);

    // add x5,x1,x2 ; sub x6,x5,x3
    issue(1, 2, 5, 1, 1, OP_ALU, 0);
    checkOutput("t1FwdAfirst", int'(fwdA), 0);
    issue(5, 3, 6, 1, 1, OP_ALU, 0);
    checkOutput("t1FwdA",    int'(fwdA),    1);
    checkOutput("t1PcEn",    int'(pcEn),    1);
    checkOutput("t1DeFlush", int'(deFlush), 0);
    idle(3);

    // add x5 ; nop ; or x7,x0,x5
    issue(1, 2, 5, 1, 1, OP_ALU, 0);
    idle(1);
    issue(0, 5, 7, 1, 1, OP_ALU, 0);
    checkOutput("t2FwdB", int'(fwdB), 2);
    checkOutput("t2FwdA", int'(fwdA), 0);
    idle(3);

    // lw x5 ; add x6,x5,x1 (held in ID across the stall)
    issue(1, 0, 5, 1, 0, OP_LOAD, 0);
    issue(5, 1, 6, 1, 1, OP_ALU, 0);
    checkOutput("t3StallPcEn",    int'(pcEn),    0);
    checkOutput("t3StallFdEn",    int'(fdEn),    0);
    checkOutput("t3StallDeFlush", int'(deFlush), 1);
    issue(5, 1, 6, 1, 1, OP_ALU, 0);
    checkOutput("t3PcEn",    int'(pcEn),    1);
    checkOutput("t3FwdA",    int'(fwdA),    3);
    checkOutput("t3DeFlush", int'(deFlush), 0);
    idle(3);

    // lw x5 ; sw x5,0(x2)
    issue(1, 0, 5, 1, 0, OP_LOAD, 0);
    issue(2, 5, 0, 1, 1, OP_STORE, 0);
    checkOutput("t4PcEn",  int'(pcEn),  1);
    checkOutput("t4FwdB",  int'(fwdB),  0);
    checkOutput("t4LsId",  int'(fwdLs), 0);
    idle(1);
    checkOutput("t4LsExe", int'(fwdLs), 0);
    idle(1);
    checkOutput("t4LsMem", int'(fwdLs), 1);
    idle(1);
    checkOutput("t4LsWb",  int'(fwdLs), 0);
    idle(2);

    // addi x0,x0,1 ; add x6,x0,x0
    issue(0, 0, 0, 1, 0, OP_ALU, 0);
    issue(0, 0, 6, 1, 1, OP_ALU, 0);
    checkOutput("t5FwdA", int'(fwdA), 0);
    checkOutput("t5FwdB", int'(fwdB), 0);
    checkOutput("t5PcEn", int'(pcEn), 1);
    idle(3);

    // lw x5 ; beq-like consumer of x5 with Branch_ID=1
    issue(1, 0, 5, 1, 0, OP_LOAD, 0);
    issue(5, 1, 0, 1, 1, OP_NONE, 1);
    checkOutput("t6StallFdFlush", int'(fdFlush), 0);
    checkOutput("t6StallPcEn",    int'(pcEn),    0);
    issue(5, 1, 0, 1, 1, OP_NONE, 1);
    checkOutput("t6FdFlush", int'(fdFlush), 1);
    checkOutput("t6PcEn",    int'(pcEn),    1);
    checkOutput("t6FwdA",    int'(fwdA),    3);
    idle(3);

    // reset asserted in the middle of a load-use stall
    issue(1, 0, 5, 1, 0, OP_LOAD, 0);
    issue(5, 1, 6, 1, 1, OP_ALU, 0);
    checkOutput("t7StallDeFlush", int'(deFlush), 1);
    rst = 1'b0;
    #2;
    checkOutput("t7RstPcEn",    int'(pcEn),    1);
    checkOutput("t7RstDeFlush", int'(deFlush), 0);
    checkOutput("t7RstFwdA",    int'(fwdA),    0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #3;
    checkOutput("t7RelPcEn",    int'(pcEn),    1);
    checkOutput("t7RelDeFlush", int'(deFlush), 0);
    checkOutput("t7RelFwdA",    int'(fwdA),    0);
    idle(2);

    // Randomized instruction stream over a small register set for dense hits.
    for (int n = 0; n < 3000; n++) begin
      int a1, a2, ad;
      a1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3));
      a2 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3));
      ad = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 39) != 0);
      applyStimulus(a1, a2, ad, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    end
    rst = 1'b1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
